// File: rtl/uart_buffered.sv
// Buffered UART with register bus, TX/RX byte FIFOs, optional parity and
// a level interrupt. Divisor is latched per frame in each direction.

module uart_buffered_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot the push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push & ~do_pop) count_d = count_q + CW'(1);
        if (do_pop & ~do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

module uart_buffered #(
    parameter int DIV_DEFAULT = 868,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_valid,
    input  logic        uart_wstrb,
    input  logic [7:0]  uart_addr,
    input  logic [15:0] uart_wdata,
    output logic        uart_ready,
    output logic [15:0] uart_rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        uart_irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    logic        ready_q, ready_d;
    logic [6:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  err_q, err_d, err_set, err_clr;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
    logic        txd_q, txd_d;

    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_par_q, rx_par_d, rx_pen_q, rx_pen_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

    logic        accept, wr, rd_act;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic        tx_busy, rx_busy, tx_end, rx_end, rx_fall;
    logic [15:0] status, level, rx_half;
    logic        perr_set, ferr_set;

    assign accept = uart_valid & ~ready_q;
    assign wr     = accept & uart_wstrb;
    assign rd_act = ready_q & uart_valid & ~uart_wstrb;

    assign tx_push = wr & (uart_addr == 8'h04);
    assign rx_pop  = rd_act & (uart_addr == 8'h06) & ~rx_empty;

    uart_buffered_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .wdata(uart_wdata[7:0]),
        .pop(tx_pop), .head(tx_head), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    uart_buffered_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh_q),
        .pop(rx_pop), .head(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    assign tx_busy = (tx_state_q != S_IDLE);
    assign rx_busy = (rx_state_q != S_IDLE);
    assign status  = {6'b0, err_q, rx_full, ~rx_empty, rx_busy,
                      tx_empty, tx_full, tx_busy};
    assign level   = {8'(rx_count), 8'(tx_count)};

    always_comb begin
        uart_rdata = '0;
        if (rd_act) begin
            case (uart_addr)
                8'h00:   uart_rdata = status;
                8'h02:   uart_rdata = {9'b0, ctrl_q};
                8'h06:   uart_rdata = rx_empty ? 16'h0 : {8'h0, rx_head};
                8'h08:   uart_rdata = div_q;
                8'h0C:   uart_rdata = level;
                default: uart_rdata = '0;
            endcase
        end
    end

    always_comb begin
        ready_d = accept;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        err_clr = '0;
        if (wr) begin
            case (uart_addr)
                8'h02:   ctrl_d = uart_wdata[6:0];
                8'h08:   div_d = (uart_wdata < 16'd4) ? 16'd4 : uart_wdata;
                8'h0A:   err_clr = uart_wdata[9:6];
                default: ;
            endcase
        end
        err_set = {tx_push & tx_full & ~tx_pop, perr_set, ferr_set,
                   rx_push & rx_full & ~rx_pop};
        err_d = (err_q & ~err_clr) | err_set;
    end

    assign tx_end = (tx_cnt_q == tx_div_q - 16'd1);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_end ? 16'd0 : tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (ctrl_q[0] & ~tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_par_d   = ctrl_q[3];
                    tx_pen_d   = ctrl_q[2];
                    tx_div_d   = div_q;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_end) begin
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_end) begin
                tx_par_d = tx_par_q ^ tx_sh_q[0];
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7)
                    tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tx_end) tx_state_d = S_STOP;
            S_STOP:   if (tx_end) tx_state_d = S_IDLE;
            default:  tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_sh_d[0];
            S_PARITY: txd_d = tx_par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    assign rx_s1_d   = rxd;
    assign rx_s2_d   = rx_s1_q;
    assign rx_prev_d = rx_s2_q;
    assign rx_fall   = rx_prev_q & ~rx_s2_q;
    assign rx_end    = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half   = {1'b0, rx_div_q[15:1]} - 16'd1;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_end ? 16'd0 : rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_pen_d   = rx_pen_q;
        rx_push    = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;
        if (rx_busy & ~ctrl_q[1]) begin
            rx_state_d = S_IDLE;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_d = '0;
                    if (ctrl_q[1] & rx_fall) begin
                        rx_div_d   = div_q;
                        rx_par_d   = ctrl_q[3];
                        rx_pen_d   = ctrl_q[2];
                        rx_state_d = S_START;
                    end
                end
                S_START: begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    if (rx_cnt_q == rx_half) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (rx_end) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_par_d = rx_par_q ^ rx_s2_q;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7)
                        rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_end) begin
                    perr_set   = rx_par_q ^ rx_s2_q;
                    rx_state_d = S_STOP;
                end
                S_STOP: if (rx_end) begin
                    ferr_set   = ~rx_s2_q;
                    rx_push    = rx_s2_q;
                    rx_state_d = S_IDLE;
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            ctrl_q     <= '0;
            div_q      <= 16'(DIV_DEFAULT);
            err_q      <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(DIV_DEFAULT);
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(DIV_DEFAULT);
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_pen_q   <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ready_q    <= ready_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            err_q      <= err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_pen_q   <= rx_pen_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
        end
    end

    assign uart_ready = ready_q;
    assign txd        = txd_q;
    assign uart_irq   = (ctrl_q[4] & ~rx_empty)
                      | (ctrl_q[5] & tx_empty & ~tx_busy)
                      | (ctrl_q[6] & (|err_q));
endmodule
